load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU. Takes the ALU result as effective address, plus funct3, store data and a load/store flag. Runs one data-memory transaction over a req/ack handshake. Produces byte enables and replicated write data for stores, and aligned, sign- or zero-extended data for loads. Misaligned or illegal accesses are flagged without touching memory.

Parameters:
TIMEOUT, 16, max cycles mem_req stays high without mem_ack before the access ends with an error; must be ≥2.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  access request from the execute stage
req_ready  out  1  unit idle and able to accept a request
is_store  in  1  1 = store, 0 = load
funct3  in  3  RV32I width/sign code
addr  in  32  effective byte address (ALU Result)
store_data  in  32  rs2 value for stores
rsp_valid  out  1  one-cycle pulse: access complete
load_data  out  32  extended load result, valid with rsp_valid
err  out  1  misaligned, illegal funct3 or timeout, valid with rsp_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wdata  out  32  replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  memory completion, at most one per mem_req
mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Clock/reset fixed: one clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; req_ready=1; rsp_valid=0; err=0; load_data=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; timeout counter=0.
- States: IDLE, ACCESS, RESP.
- req_ready=1 only in IDLE. Request is accepted when req_valid && req_ready. The unit latches is_store, funct3, addr[1:0] and store_data.
- Legal codes. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Illegal or misaligned request: IDLE→RESP. Next cycle rsp_valid=1, err=1, load_data=0. mem_req is never asserted.
- Legal request: IDLE→ACCESS. From the next cycle: mem_req=1, mem_we=is_store, mem_addr word-aligned.
- Store byte enables: SB = 4'b0001<<addr[1:0]; SH = addr[1] ? 4'b1100 : 4'b0011; SW = 4'b1111.
- Store write data: SB = {4{data[7:0]}}; SH = {2{data[15:0]}}; SW = data.
- Loads drive mem_be=4'b1111 and mem_wdata=0.
- ACCESS holds all mem_* outputs stable until mem_ack.
- On mem_ack: mem_req/mem_we/mem_be clear next cycle. State→RESP. For a load, the selected lane (mem_rdata>>8*addr[1:0]) is extended into load_data: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Timeout: counter runs while in ACCESS and resets on entry. If TIMEOUT cycles of mem_req pass with no mem_ack, the unit drops mem_req and goes to RESP with err=1, load_data=0. If mem_ack arrives in the same cycle the count expires, the ack wins (no error).
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns to 1 in the cycle after the rsp_valid pulse.
- Stores: load_data=0 and err=0 on a successful response.
- Latency: accept at cycle 0. mem_req is high from cycle 1. Ack at cycle k gives rsp_valid at cycle k+1. Minimum total is 2 cycles. Error path is 1 cycle.
- req_valid is ignored outside IDLE, with no queuing.
- mem_ack is ignored outside ACCESS.
- Reset mid-access: at the reset edge all outputs return to reset values. Any pending ack is discarded and no rsp_valid is produced.

Test Plan:
- LW addr=0x100, mem_ack on first mem_req cycle, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_be=1111, rsp_valid at cycle 2, load_data=0xDEADBEEF, err=0.
- LB addr=0x103, rdata=0x80112233 → load_data=0xFFFFFF80. LBU same access → 0x00000080. LHU addr=0x102, rdata=0x8001_0000 → 0x00008001.
- SB addr=0x201, store_data=0x000000A5 → mem_we=1, mem_addr=0x200, mem_be=0010, mem_wdata=0xA5A5A5A5. SH addr=0x202, data=0x1234 → mem_be=1100, mem_wdata=0x12341234.
- LW addr=0x102 and LH addr=0x101 → mem_req never rises, rsp_valid at cycle 1 with err=1. funct3=011 on a load → err=1.
- TIMEOUT=16, mem_ack held low → mem_req high exactly 16 cycles, then rsp_valid with err=1. Ack on cycle 16 → err=0.
- Reset asserted while mem_req=1 → next cycle mem_req=0 and req_ready=1. A late mem_ack causes no rsp_valid. Back-to-back requests: the second is accepted only when req_ready=1 again.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU effective address into one req/ack data-memory
// transaction, with store lane steering and load extension; bad accesses never reach memory.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t        r_state,     w_state;
  logic          r_is_store,  w_is_store;
  logic [2:0]    r_funct3,    w_funct3;
  logic [1:0]    r_lane,      w_lane;
  logic [CW-1:0] r_cnt,       w_cnt;
  logic          r_req_ready, w_req_ready;
  logic          r_rsp_valid, w_rsp_valid;
  logic          r_err,       w_err;
  logic [31:0]   r_load_data, w_load_data;
  logic          r_mem_req,   w_mem_req;
  logic          r_mem_we,    w_mem_we;
  logic [31:0]   r_mem_addr,  w_mem_addr;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic [3:0]    r_mem_be,    w_mem_be;

  logic          w_legal;
  logic [3:0]    w_store_be;
  logic [31:0]   w_store_wdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ext;

  // Width/sign code legality plus natural alignment of the incoming request.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000: w_legal = 1'b1;
      3'b001: w_legal = ~addr[0];
      3'b010: w_legal = (addr[1:0] == 2'b00);
      3'b100: w_legal = ~is_store;
      3'b101: w_legal = ~is_store & ~addr[0];
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        w_store_be    = 4'b0001 << addr[1:0];
        w_store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_store_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_store_be    = 4'b1111;
        w_store_wdata = store_data;
      end
    endcase
  end

  // The addressed lane is shifted down to bit 0; word loads always have lane 0.
  assign w_shifted = mem_rdata >> {r_lane, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_ext = w_shifted;
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = 32'd0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value defaults to its current register first, so no
    // path through the case below can leave a variable unassigned and infer a latch.
    w_state     = r_state;
    w_is_store  = r_is_store;
    w_funct3    = r_funct3;
    w_lane      = r_lane;
    w_cnt       = r_cnt;
    w_req_ready = r_req_ready;
    w_rsp_valid = r_rsp_valid;
    w_err       = r_err;
    w_load_data = r_load_data;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_be    = r_mem_be;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_is_store  = is_store;
          w_funct3    = funct3;
          w_lane      = addr[1:0];
          w_cnt       = '0;
          w_req_ready = 1'b0;
          if (w_legal) begin
            w_state     = S_ACCESS;
            w_mem_req   = 1'b1;
            w_mem_we    = is_store;
            w_mem_addr  = {addr[31:2], 2'b00};
            w_mem_be    = is_store ? w_store_be : 4'b1111;
            w_mem_wdata = is_store ? w_store_wdata : 32'd0;
          end else begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_err       = 1'b1;
            w_load_data = 32'd0;
          end
        end
      end

      S_ACCESS: begin
        // An ack on the expiry cycle completes normally.
        if (mem_ack || (r_cnt == CW'(TIMEOUT - 1))) begin
          w_state     = S_RESP;
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_mem_be    = 4'b0000;
          w_rsp_valid = 1'b1;
          w_err       = ~mem_ack;
          w_load_data = (mem_ack && !r_is_store) ? w_ext : 32'd0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      S_RESP: begin
        w_state     = S_IDLE;
        w_req_ready = 1'b1;
        w_rsp_valid = 1'b0;
        w_err       = 1'b0;
        w_load_data = 32'd0;
      end

      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_lane      <= 2'b00;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load_data <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'b0000;
    end else begin
      r_state     <= w_state;
      r_is_store  <= w_is_store;
      r_funct3    <= w_funct3;
      r_lane      <= w_lane;
      r_cnt       <= w_cnt;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_err       <= w_err;
      r_load_data <= w_load_data;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_be    <= w_mem_be;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign err       = r_err;
  assign load_data = r_load_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of accesses with a response
// scoreboard, plus hand sequences for timeout, reset mid-access and back-to-back.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic [31:0] load_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb_q[$];

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rsp_valid  (rsp_valid),
    .load_data  (load_data),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input logic e,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd;
    v.exp_err = e; v.exp_be = be; v.exp_wdata = wd; v.exp_load = ld;
    return v;
  endfunction

  task automatic check_rsp(input string name);
    rsp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_err"}, {31'd0, err}, {31'd0, e.err});
      check({name, "_load_data"}, load_data, e.data);
    end
  endtask

  // Issue one request; the memory acks on the ack_after-th cycle of mem_req (0 = never).
  task automatic run_access(input string name, input vec_t v, input int ack_after);
    rsp_t e;
    int   cyc;
    int   reqs;
    int   exp_reqs;
    check({name, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    is_store   = v.st;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sdata;
    req_valid  = 1'b1;
    e.err  = v.exp_err || (ack_after == 0);
    e.data = e.err ? 32'd0 : v.exp_load;
    sb_q.push_back(e);
    tick();
    req_valid = 1'b0;
    cyc  = 1;
    reqs = 0;
    while (!rsp_valid && cyc < 40) begin
      if (mem_req) begin
        reqs++;
        check({name, "_mem_addr"},  mem_addr,  {v.addr[31:2], 2'b00});
        check({name, "_mem_we"},    {31'd0, mem_we}, {31'd0, v.st});
        check({name, "_mem_be"},    {28'd0, mem_be}, {28'd0, v.exp_be});
        check({name, "_mem_wdata"}, mem_wdata, v.exp_wdata);
        check({name, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
        if (reqs == ack_after) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      cyc++;
    end
    exp_reqs = v.exp_err ? 0 : ((ack_after == 0) ? TIMEOUT : ack_after);
    check({name, "_mem_req_cycles"}, reqs, exp_reqs);
    check({name, "_latency"}, cyc, exp_reqs + 1);
    check({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid) begin
      check_rsp(name);
      check({name, "_mem_req_done"}, {31'd0, mem_req}, 32'd0);
      check({name, "_mem_be_done"}, {28'd0, mem_be}, 32'd0);
    end else begin
      void'(sb_q.pop_front());
    end
    tick();
    check({name, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t tv;
    reset      = 1'b1;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'd0;
    store_data = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;

    //          st    f3      addr          sdata         rdata         err  be       wdata         load
    vecs.push_back(mk(1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'b1111, 32'h0,        32'h00000080));
    vecs.push_back(mk(1'b0, 3'b101, 32'h102, 32'h0,        32'h80010000, 1'b0, 4'b1111, 32'h0,        32'h00008001));
    vecs.push_back(mk(1'b0, 3'b001, 32'h102, 32'h0,        32'h80010000, 1'b0, 4'b1111, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1'b0, 4'b1111, 32'h0,        32'h0000007F));
    vecs.push_back(mk(1'b0, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 1'b0, 4'b1111, 32'h0,        32'hFFFFF00D));
    vecs.push_back(mk(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'h12341234, 32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h200, 32'hABCD5678, 32'hFFFFFFFF, 1'b0, 4'b0011, 32'h56785678, 32'h0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h203, 32'h7777773C, 32'hFFFFFFFF, 1'b0, 4'b1000, 32'h3C3C3C3C, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h301, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h203, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0));

    @(negedge clk);
    tick();
    reset = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_load_data", load_data,          32'd0);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  mem_addr,           32'd0);
    check("rst_mem_wdata", mem_wdata,          32'd0);
    check("rst_mem_be",    {28'd0, mem_be},    32'd0);

    foreach (vecs[i]) begin
      run_access($sformatf("vec%0d", i), vecs[i], (i % 3) + 1);
    end

    tv = mk(1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 1'b0, 4'b1111, 32'h0, 32'h11223344);
    run_access("timeout", tv, 0);
    run_access("ack_at_expiry", tv, TIMEOUT);

    // Reset while mem_req is high: no response, late ack ignored.
    is_store  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h500;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid_mem_req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_mem_req",   {31'd0, mem_req},   32'd0);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_mem_addr",  mem_addr,           32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late_ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("late_ack_mem_req",   {31'd0, mem_req},   32'd0);
      tick();
    end

    // Back-to-back: second request held valid during the first is taken only once idle.
    is_store   = 1'b0;
    funct3     = 3'b010;
    addr       = 32'h500;
    req_valid  = 1'b1;
    sb_q.push_back('{err: 1'b0, data: 32'h55AA55AA});
    tick();
    is_store   = 1'b1;
    addr       = 32'h600;
    store_data = 32'h0BADBEEF;
    check("b2b_a_mem_addr", mem_addr, 32'h500);
    check("b2b_a_mem_we",   {31'd0, mem_we}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA55AA;
    tick();
    mem_ack = 1'b0;
    check("b2b_a_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_rsp("b2b_a");
    check("b2b_ready_in_resp", {31'd0, req_ready}, 32'd0);
    tick();
    check("b2b_ready_back", {31'd0, req_ready}, 32'd1);
    check("b2b_no_req_yet", {31'd0, mem_req},   32'd0);
    sb_q.push_back('{err: 1'b0, data: 32'h0});
    tick();
    req_valid = 1'b0;
    check("b2b_b_mem_req",   {31'd0, mem_req}, 32'd1);
    check("b2b_b_mem_we",    {31'd0, mem_we},  32'd1);
    check("b2b_b_mem_addr",  mem_addr,         32'h600);
    check("b2b_b_mem_be",    {28'd0, mem_be},  32'hF);
    check("b2b_b_mem_wdata", mem_wdata,        32'h0BADBEEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b_b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_rsp("b2b_b");
    tick();
    check("b2b_b_single_req", {31'd0, mem_req},   32'd0);
    check("b2b_b_rsp_pulse",  {31'd0, rsp_valid}, 32'd0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
